hood_mode_fsm: RTL and testbench
================================

HOOD_MODE_FSM -- requirements
Module: hood_mode_fsm

Interface
REQ-001 SHALL have parameter TIME_W, 8, width of the countdown and time_left in seconds.
REQ-002 SHALL have parameter HURR_TIME, 60, hurricane run time in ticks; legal range 1..2^TIME_W-1.
REQ-003 SHALL have parameter HURR_EXIT_TIME, 60, hurricane-to-standby drain time in ticks; legal range 1..2^TIME_W-1.
REQ-004 SHALL have parameter CLEAN_TIME, 180, self-clean time in ticks; legal range 1..2^TIME_W-1.
REQ-005 SHALL have parameter IDLE_TIME, 30, menu idle timeout in ticks; used only when HOOD_AUTO_OFF_EN is defined.
REQ-006 SHALL have port clk  in  1  system clock; the only clock.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port tick  in  1  one-cycle 1 Hz strobe synchronous to clk.
REQ-009 SHALL have port power_en  in  1  master enable, level.
REQ-010 SHALL have port btn  in  5  one-cycle debounced pulses: [4] menu, [3] level1, [2] level2, [1] hurricane, [0] clean.
REQ-011 SHALL have port state  out  3  current state code.
REQ-012 SHALL have port fan_level  out  2  0 off, 1 low, 2 high, 3 hurricane.
REQ-013 SHALL have port time_left  out  TIME_W  remaining seconds of the active countdown, 0 when none is active.
REQ-014 SHALL have port hurr_avail  out  1  hurricane still permitted this power cycle.
REQ-015 SHALL have port mode_led  out  7  one-hot, bit i set when state==i.

Function
REQ-016 SHALL implement the states OFF=0, STANDBY=1, MENU=2, LEVEL1=3, LEVEL2=4, HURRICANE=5 and CLEAN=6 as a registered FSM that updates on clk.
REQ-017 SHALL treat btn as a valid press only when it is one-hot; zero or several bits set in one cycle is no press.
REQ-018 SHALL leave OFF for STANDBY when power_en is high, and enter OFF from any state the cycle after power_en is low; the power_en check overrides all other transitions.
REQ-019 SHALL implement the transitions STANDBY -menu-> MENU, MENU -level1-> LEVEL1, MENU -level2-> LEVEL2, LEVEL1 <-> LEVEL2 on level2/level1, and LEVEL1/LEVEL2 -menu-> MENU.
REQ-020 SHALL enter HURRICANE from MENU on hurricane only when hurr_avail=1, and otherwise ignore the press.
REQ-021 SHALL clear hurr_avail on entry to HURRICANE and set it again only on reset or on entry to OFF.
REQ-022 SHALL enter CLEAN from MENU on clean.
REQ-023 SHALL load the single countdown with T on the state-entry edge, decrement it on each tick, and take the exit transition on the edge where tick=1 and count==1, so that exactly T ticks elapse.
REQ-024 SHALL load HURR_TIME on HURRICANE entry and go to LEVEL2 when it expires.
REQ-025 SHALL reload the countdown with HURR_EXIT_TIME, once only, on menu in HURRICANE, then go to STANDBY on expiry; later menu presses in HURRICANE are ignored.
REQ-026 SHALL load CLEAN_TIME on CLEAN entry, ignore all buttons in CLEAN, and go to STANDBY on expiry.
REQ-027 SHALL give timer expiry priority over a button press in the same cycle.
REQ-028 SHALL drive fan_level 0 in OFF/STANDBY/MENU/CLEAN, 1 in LEVEL1, 2 in LEVEL2 and 3 in HURRICANE, registered alongside state.
REQ-029 SHALL hold time_left at 0 in every state that has no active countdown.

Reset
REQ-030 SHALL on reset set state=OFF, fan_level=0, time_left=0, hurr_avail=1, mode_led=7'b0000001 and clear the drain flag; reset has priority over power_en.

Configuration
REQ-031 SHALL, when HOOD_AUTO_OFF_EN is defined, load IDLE_TIME on MENU entry, reload it on any valid press that stays in MENU, and go to STANDBY on expiry.
REQ-032 SHALL, when HOOD_AUTO_OFF_EN is not defined, keep MENU indefinitely with time_left=0 and leave IDLE_TIME unused.

Structure
REQ-033 SHALL place the state encodings, the fan-level codes and the button bit indices in the shared package hood_pkg.
REQ-034 SHALL implement the loadable, tick-decremented counter as sub-module hood_countdown (ports clk, reset, load, load_val, tick, count, expire), with a single instance.

Verification
REQ-035 SHALL cover: reset, power_en=1, then menu, level1, level2 pulses -> states STANDBY, MENU, LEVEL1, LEVEL2 and fan_level 0, 0, 1, 2.
REQ-036 SHALL cover: HURR_TIME=3, hurricane from MENU, 3 ticks -> time_left 3, 2, 1, then LEVEL2 on the third tick, hurr_avail=0.
REQ-037 SHALL cover: second hurricane press in MENU with hurr_avail=0 -> state stays MENU; power_en low then high -> OFF, then STANDBY with hurr_avail=1.
REQ-038 SHALL cover: HURR_EXIT_TIME=2, menu at time_left=2 in HURRICANE -> reload to 2, extra menu ignored, STANDBY after 2 ticks.
REQ-039 SHALL cover: CLEAN_TIME=4 with btn 5'b11000 in MENU -> ignored; clean press -> CLEAN, buttons ignored, STANDBY after 4 ticks; tick and level1 in the same cycle at count 1 -> expiry wins.
REQ-040 SHALL cover: HOOD_AUTO_OFF_EN with IDLE_TIME=2 -> MENU returns to STANDBY after 2 idle ticks; without the macro, MENU holds for 10 ticks.

Source files
------------

// File: rtl/hood_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hood_pkg
// Description : State encodings, fan-level codes and button bit indices
//               shared by the range-hood mode controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hood_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_STANDBY   = 3'd1,
        ST_MENU      = 3'd2,
        ST_LEVEL1    = 3'd3,
        ST_LEVEL2    = 3'd4,
        ST_HURRICANE = 3'd5,
        ST_CLEAN     = 3'd6
    } state_t;

    localparam logic [1:0] c_fan_off  = 2'd0;
    localparam logic [1:0] c_fan_low  = 2'd1;
    localparam logic [1:0] c_fan_high = 2'd2;
    localparam logic [1:0] c_fan_hurr = 2'd3;

    localparam int c_btn_menu   = 4;
    localparam int c_btn_level1 = 3;
    localparam int c_btn_level2 = 2;
    localparam int c_btn_hurr   = 1;
    localparam int c_btn_clean  = 0;

    function automatic logic is_onehot(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    function automatic logic [1:0] fan_of(input state_t s);
        case (s)
            ST_LEVEL1:    return c_fan_low;
            ST_LEVEL2:    return c_fan_high;
            ST_HURRICANE: return c_fan_hurr;
            default:      return c_fan_off;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/hood_countdown.sv
`default_nettype none
// ============================================================================
// Module      : hood_countdown
// Description : Loadable seconds counter, decremented on tick, expire pulses
//               on the tick that would take it from 1 to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module hood_countdown #(
    parameter int TIME_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic              tick,
    output logic [TIME_W-1:0] count,
    output logic              expire
);

    logic [TIME_W-1:0] r_count;

    // A load always wins over a decrement in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count  = r_count;
    assign expire = tick && (r_count == TIME_W'(1));

endmodule
`default_nettype wire

// File: rtl/hood_mode_fsm.sv
`default_nettype none
// ============================================================================
// Module      : hood_mode_fsm
// Description : Range-hood mode controller (standby/menu/levels/hurricane/
//               self-clean) with one shared countdown.
//               Option macro HOOD_AUTO_OFF_EN: MENU idle timeout to STANDBY.
// Revision    : 1.0 - initial release
// ============================================================================
module hood_mode_fsm
    import hood_pkg::*;
#(
    parameter int TIME_W         = 8,
    parameter int HURR_TIME      = 60,
    parameter int HURR_EXIT_TIME = 60,
    parameter int CLEAN_TIME     = 180,
    parameter int IDLE_TIME      = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              power_en,
    input  logic [4:0]        btn,
    output logic [2:0]        state,
    output logic [1:0]        fan_level,
    output logic [TIME_W-1:0] time_left,
    output logic              hurr_avail,
    output logic [6:0]        mode_led
);

`ifdef HOOD_AUTO_OFF_EN
    localparam bit c_auto_off = 1'b1;
`else
    localparam bit c_auto_off = 1'b0;
`endif

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_fan;
    logic              r_hurr_avail;
    logic              r_drain;
    logic              w_press;
    logic              w_reload;
    logic [TIME_W-1:0] w_reload_val;
    logic              w_drain_set;
    logic              w_load;
    logic [TIME_W-1:0] w_load_val;
    logic [TIME_W-1:0] w_count;
    logic              w_expire;

    assign w_press = is_onehot(btn);

    always_comb begin
        w_next       = r_state;
        w_reload     = 1'b0;
        w_reload_val = '0;
        w_drain_set  = 1'b0;
        if (!power_en) begin
            w_next = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF: w_next = ST_STANDBY;
                ST_STANDBY: begin
                    if (w_press && btn[c_btn_menu]) w_next = ST_MENU;
                end
                ST_MENU: begin
                    if (c_auto_off && w_expire) begin
                        w_next = ST_STANDBY;
                    end else if (w_press) begin
                        if (btn[c_btn_level1])                    w_next = ST_LEVEL1;
                        else if (btn[c_btn_level2])               w_next = ST_LEVEL2;
                        else if (btn[c_btn_clean])                w_next = ST_CLEAN;
                        else if (btn[c_btn_hurr] && r_hurr_avail) w_next = ST_HURRICANE;
                        else begin
                            // Press that leaves us in MENU restarts the idle timer.
                            w_reload     = c_auto_off;
                            w_reload_val = TIME_W'(IDLE_TIME);
                        end
                    end
                end
                ST_LEVEL1: begin
                    if (w_press && btn[c_btn_level2])    w_next = ST_LEVEL2;
                    else if (w_press && btn[c_btn_menu]) w_next = ST_MENU;
                end
                ST_LEVEL2: begin
                    if (w_press && btn[c_btn_level1])    w_next = ST_LEVEL1;
                    else if (w_press && btn[c_btn_menu]) w_next = ST_MENU;
                end
                ST_HURRICANE: begin
                    if (w_expire) begin
                        w_next = r_drain ? ST_STANDBY : ST_LEVEL2;
                    end else if (w_press && btn[c_btn_menu] && !r_drain) begin
                        w_reload     = 1'b1;
                        w_reload_val = TIME_W'(HURR_EXIT_TIME);
                        w_drain_set  = 1'b1;
                    end
                end
                ST_CLEAN: begin
                    if (w_expire) w_next = ST_STANDBY;
                end
                default: w_next = ST_OFF;
            endcase
        end
    end

    // Every state change reloads the counter; untimed states load zero.
    always_comb begin
        w_load     = w_reload;
        w_load_val = w_reload_val;
        if (w_next != r_state) begin
            w_load = 1'b1;
            case (w_next)
                ST_HURRICANE: w_load_val = TIME_W'(HURR_TIME);
                ST_CLEAN:     w_load_val = TIME_W'(CLEAN_TIME);
                ST_MENU:      w_load_val = c_auto_off ? TIME_W'(IDLE_TIME) : '0;
                default:      w_load_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_OFF;
            r_fan        <= c_fan_off;
            r_hurr_avail <= 1'b1;
            r_drain      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_fan   <= fan_of(w_next);
            if (w_next == ST_OFF) begin
                r_hurr_avail <= 1'b1;
            end else if (w_next == ST_HURRICANE && r_state != ST_HURRICANE) begin
                r_hurr_avail <= 1'b0;
            end
            if (w_next != ST_HURRICANE || r_state != ST_HURRICANE) begin
                r_drain <= 1'b0;
            end else if (w_drain_set) begin
                r_drain <= 1'b1;
            end
        end
    end

    hood_countdown #(
        .TIME_W (TIME_W)
    ) u_countdown (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (tick),
        .count    (w_count),
        .expire   (w_expire)
    );

    assign state      = r_state;
    assign fan_level  = r_fan;
    assign time_left  = w_count;
    assign hurr_avail = r_hurr_avail;
    assign mode_led   = 7'd1 << r_state;

endmodule
`default_nettype wire

// File: tb/tb_hood_mode_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_hood_mode_fsm
// Description : Directed self-checking bench for hood_mode_fsm; the MENU idle
//               case follows HOOD_AUTO_OFF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hood_mode_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       power_en;
    logic [4:0] btn;
    logic [2:0] state;
    logic [1:0] fan_level;
    logic [7:0] time_left;
    logic       hurr_avail;
    logic [6:0] mode_led;

    int checks   = 0;
    int failures = 0;

    hood_mode_fsm #(
        .TIME_W         (8),
        .HURR_TIME      (3),
        .HURR_EXIT_TIME (2),
        .CLEAN_TIME     (4),
        .IDLE_TIME      (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .power_en   (power_en),
        .btn        (btn),
        .state      (state),
        .fan_level  (fan_level),
        .time_left  (time_left),
        .hurr_avail (hurr_avail),
        .mode_led   (mode_led)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] b);
        btn = b;
        step();
        btn = 5'd0;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic expect_st(input string tag, input int st, input int fan, input int tl);
        check_eq({tag, "_state"}, 32'(state), 32'(st));
        check_eq({tag, "_fan"},   32'(fan_level), 32'(fan));
        check_eq({tag, "_tl"},    32'(time_left), 32'(tl));
        check_eq({tag, "_led"},   32'(mode_led), 32'(1 << st));
    endtask

    initial begin
        reset = 1'b1; power_en = 1'b0; btn = 5'd0; tick = 1'b0;
        step(); step();
        expect_st("reset", 0, 0, 0);
        check_eq("reset_hurr", 32'(hurr_avail), 32'd1);
        power_en = 1'b1;
        step();
        expect_st("reset_over_power", 0, 0, 0);
        reset = 1'b0;
        step();
        expect_st("power_on", 1, 0, 0);

        press(5'b10000); check_eq("menu", 32'(state), 32'd2);
        press(5'b01000); expect_st("level1", 3, 1, 0);
        press(5'b00100); expect_st("level2", 4, 2, 0);
        press(5'b01000); expect_st("back_l1", 3, 1, 0);
        press(5'b10000); expect_st("l1_menu", 2, 0, c_idle_tl());

        press(5'b00010); expect_st("hurr", 5, 3, 3);
        check_eq("hurr_avail_clr", 32'(hurr_avail), 32'd0);
        tick_once(); expect_st("hurr_t1", 5, 3, 2);
        tick_once(); expect_st("hurr_t2", 5, 3, 1);
        tick_once(); expect_st("hurr_exp", 4, 2, 0);
        check_eq("hurr_avail_after", 32'(hurr_avail), 32'd0);

        press(5'b10000);
        press(5'b00010); check_eq("hurr_blocked", 32'(state), 32'd2);
        power_en = 1'b0; step();
        expect_st("power_off", 0, 0, 0);
        check_eq("off_hurr_avail", 32'(hurr_avail), 32'd1);
        power_en = 1'b1; step();
        expect_st("repower", 1, 0, 0);

        press(5'b10000);
        press(5'b00010); expect_st("hurr2", 5, 3, 3);
        tick_once();     check_eq("hurr2_tl", 32'(time_left), 32'd2);
        press(5'b10000); expect_st("drain_load", 5, 3, 2);
        tick_once();     check_eq("drain_t1", 32'(time_left), 32'd1);
        press(5'b10000); expect_st("drain_ignore", 5, 3, 1);
        tick_once();     expect_st("drain_exp", 1, 0, 0);

        press(5'b10000);
        press(5'b11000); check_eq("multi_btn", 32'(state), 32'd2);
        press(5'b00001); expect_st("clean", 6, 0, 4);
        press(5'b01000); expect_st("clean_ignore", 6, 0, 4);
        tick_once();     check_eq("clean_t1", 32'(time_left), 32'd3);
        press(5'b10000); expect_st("clean_menu_ign", 6, 0, 3);
        tick_once(); tick_once();
        check_eq("clean_t3", 32'(time_left), 32'd1);
        btn = 5'b01000; tick = 1'b1; step(); btn = 5'd0; tick = 1'b0;
        expect_st("expiry_wins", 1, 0, 0);

        press(5'b10000);
`ifdef HOOD_AUTO_OFF_EN
        expect_st("idle_menu", 2, 0, 2);
        tick_once(); expect_st("idle_t1", 2, 0, 1);
        tick_once(); expect_st("idle_exp", 1, 0, 0);
`else
        for (int i = 0; i < 10; i++) begin
            tick_once();
            expect_st("menu_hold", 2, 0, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic int c_idle_tl();
`ifdef HOOD_AUTO_OFF_EN
        return 2;
`else
        return 0;
`endif
    endfunction

    import hood_pkg::*;

endmodule
`default_nettype wire
